// File: rtl/cachepkg.sv
// Shared cache types: the operation encoding used on every cache port,
// plus the state encoding and size limit of the request arbiter.
package cachepkg;

    localparam int ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        INST_NOP   = 2'd0,
        INST_READ  = 2'd1,
        INST_WRITE = 2'd2,
        INST_FLUSH = 2'd3
    } inst_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_HOLD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_pick.sv
// Combinational winner selection for cache_arbiter. Round-robin by default;
// CACHE_ARB_FIXED_PRIO_EN selects lowest-index fixed priority instead.
module arb_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDW-1:0]     last_grant_i,
    output logic [IDW-1:0]     winner_o,
    output logic               any_o
);

    assign any_o = |pending_i;

`ifdef CACHE_ARB_FIXED_PRIO_EN
    logic unusedLastGrant;
    assign unusedLastGrant = ^last_grant_i;

    // Scan downwards so the lowest pending index is the last one written.
    always_comb begin
        winner_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending_i[IDW'(i)]) winner_o = IDW'(i);
        end
    end
`else
    logic           found;
    logic [IDW-1:0] idx;

    // Search starts one past the previous winner and wraps around.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDW'((int'(last_grant_i) + i) % NUM_REQ);
            if (!found && pending_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one cache slave port among NUM_REQ 4-phase requesters.
// Define CACHE_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module cache_arbiter
    import cachepkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 32,
    parameter int NUM_REQ      = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_request,
    input  inst_t [NUM_REQ-1:0]                    req_operation,
    input  logic [NUM_REQ-1:0][ADDRESSWIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_evict,
    output logic [DATAWIDTH-1:0]                   req_rdata,
    output inst_t                                  cache_operation,
    output logic [ADDRESSWIDTH-1:0]                cache_addr,
    output logic [DATAWIDTH-1:0]                   cache_wdata,
    output logic                                   cache_request,
    input  logic [DATAWIDTH-1:0]                   cache_rdata,
    input  logic                                   cache_valid,
    input  logic                                   cache_evict,
    output logic [$clog2(NUM_REQ)-1:0]             grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("cache_arbiter: NUM_REQ out of range");
    end

    arb_state_t                state_q;
    logic [IDW-1:0]            grant_q;
    logic [IDW-1:0]            lastGrant_q;
    inst_t                     op_q;
    logic [ADDRESSWIDTH-1:0]   addr_q;
    logic [DATAWIDTH-1:0]      wdata_q;
    logic                      cacheReq_q;
    logic [NUM_REQ-1:0]        reqValid_q;
    logic [NUM_REQ-1:0]        reqEvict_q;
    logic [DATAWIDTH-1:0]      rdata_q;

    logic [IDW-1:0]            winner;
    logic                      anyPending;

    arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .pending_i    (req_request),
        .last_grant_i (lastGrant_q),
        .winner_o     (winner),
        .any_o        (anyPending)
    );

    // Grant, forward to cache, return completion, then wait for both sides
    // of the handshake to drop before the next grant.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            lastGrant_q <= IDW'(NUM_REQ - 1);
            op_q        <= INST_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            cacheReq_q  <= 1'b0;
            reqValid_q  <= '0;
            reqEvict_q  <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (anyPending) begin
                        grant_q     <= winner;
                        lastGrant_q <= winner;
                        op_q        <= req_operation[winner];
                        addr_q      <= req_addr[winner];
                        wdata_q     <= req_wdata[winner];
                        cacheReq_q  <= 1'b1;
                        state_q     <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (cache_valid) begin
                        rdata_q    <= cache_rdata;
                        reqValid_q <= ONE_HOT0 << grant_q;
                        reqEvict_q <= cache_evict ? (ONE_HOT0 << grant_q) : '0;
                        cacheReq_q <= 1'b0;
                        state_q    <= ARB_HOLD;
                    end
                end
                ARB_HOLD: begin
                    if (!req_request[grant_q] && !cache_valid) begin
                        reqValid_q <= '0;
                        reqEvict_q <= '0;
                        state_q    <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign grant_id        = grant_q;
    assign cache_operation = op_q;
    assign cache_addr      = addr_q;
    assign cache_wdata     = wdata_q;
    assign cache_request   = cacheReq_q;
    assign req_valid       = reqValid_q;
    assign req_evict       = reqEvict_q;
    assign req_rdata       = rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter with two requesters.
// Honors CACHE_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_cache_arbiter;
    import cachepkg::*;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       reqRequest;
    inst_t [1:0]      reqOperation;
    logic [1:0][31:0] reqAddr;
    logic [1:0][7:0]  reqWdata;
    logic [1:0]       reqValid;
    logic [1:0]       reqEvict;
    logic [7:0]       reqRdata;
    inst_t            cacheOperation;
    logic [31:0]      cacheAddr;
    logic [7:0]       cacheWdata;
    logic             cacheRequest;
    logic [7:0]       cacheRdata;
    logic             cacheValid;
    logic             cacheEvict;
    logic [0:0]       grantId;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cache_arbiter #(
        .DATAWIDTH    (8),
        .ADDRESSWIDTH (32),
        .NUM_REQ      (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_request     (reqRequest),
        .req_operation   (reqOperation),
        .req_addr        (reqAddr),
        .req_wdata       (reqWdata),
        .req_valid       (reqValid),
        .req_evict       (reqEvict),
        .req_rdata       (reqRdata),
        .cache_operation (cacheOperation),
        .cache_addr      (cacheAddr),
        .cache_wdata     (cacheWdata),
        .cache_request   (cacheRequest),
        .cache_rdata     (cacheRdata),
        .cache_valid     (cacheValid),
        .cache_evict     (cacheEvict),
        .grant_id        (grantId)
    );

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        reset      = 1'b1;
        reqRequest = 2'b00;
        cacheValid = 1'b0;
        cacheEvict = 1'b0;
        cacheRdata = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reqOperation[0] = INST_WRITE;
        reqOperation[1] = INST_READ;
        reqAddr[0]  = 32'h0000_0100;
        reqAddr[1]  = 32'h0000_0200;
        reqWdata[0] = 8'hA5;
        reqWdata[1] = 8'h77;
        applyReset();
        checks++;
        if (cacheRequest !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_cache_request: got %b expected 0", cacheRequest);
        end
        checks++;
        if (reqValid !== 2'b00 || reqEvict !== 2'b00) begin
            errors++; $display("[TB] FAIL reset_valid_evict: got %b/%b expected 00/00", reqValid, reqEvict);
        end
        checks++;
        if (grantId !== 1'b0 || cacheAddr !== 32'h0 || cacheWdata !== 8'h0 || cacheOperation !== INST_NOP || reqRdata !== 8'h0) begin
            errors++; $display("[TB] FAIL reset_buses: got id=%0d addr=%h wdata=%h op=%0d rdata=%h expected all 0",
                               grantId, cacheAddr, cacheWdata, cacheOperation, reqRdata);
        end
    endtask

    task automatic test_single_request();
        applyReset();
        reqRequest = 2'b01;
        tick();
        checks++;
        if (cacheRequest !== 1'b1 || cacheAddr !== 32'h100 || cacheWdata !== 8'hA5 || cacheOperation !== INST_WRITE || grantId !== 1'b0) begin
            errors++; $display("[TB] FAIL single_grant: got req=%b addr=%h wdata=%h op=%0d id=%0d expected 1/100/a5/2/0",
                               cacheRequest, cacheAddr, cacheWdata, cacheOperation, grantId);
        end
        tick();
        checks++;
        if (cacheRequest !== 1'b1 || reqValid !== 2'b00) begin
            errors++; $display("[TB] FAIL single_wait: got req=%b valid=%b expected 1/00", cacheRequest, reqValid);
        end
        cacheValid = 1'b1;
        cacheRdata = 8'h3C;
        cacheEvict = 1'b0;
        tick();
        checks++;
        if (reqValid !== 2'b01 || reqRdata !== 8'h3C || reqEvict !== 2'b00 || cacheRequest !== 1'b0) begin
            errors++; $display("[TB] FAIL single_complete: got valid=%b rdata=%h evict=%b req=%b expected 01/3c/00/0",
                               reqValid, reqRdata, reqEvict, cacheRequest);
        end
        reqRequest = 2'b00;
        tick();
        checks++;
        if (reqValid !== 2'b01) begin
            errors++; $display("[TB] FAIL single_hold: got valid=%b expected 01", reqValid);
        end
        cacheValid = 1'b0;
        tick();
        checks++;
        if (reqValid !== 2'b00 || cacheAddr !== 32'h100 || cacheWdata !== 8'hA5) begin
            errors++; $display("[TB] FAIL single_release: got valid=%b addr=%h wdata=%h expected 00/100/a5",
                               reqValid, cacheAddr, cacheWdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:0] expOrder [4];
`ifdef CACHE_ARB_FIXED_PRIO_EN
        expOrder = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        applyReset();
        reqRequest = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (grantId !== expOrder[t] || cacheAddr !== reqAddr[expOrder[t]] || cacheRequest !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_grant%0d: got id=%0d addr=%h req=%b expected id=%0d addr=%h req=1",
                                   t, grantId, cacheAddr, cacheRequest, expOrder[t], reqAddr[expOrder[t]]);
            end
            cacheValid = 1'b1;
            cacheRdata = 8'(8'h10 + t);
            tick();
            checks++;
            if (reqValid !== (2'b01 << expOrder[t]) || reqRdata !== 8'(8'h10 + t)) begin
                errors++; $display("[TB] FAIL b2b_valid%0d: got valid=%b rdata=%h expected %b/%h",
                                   t, reqValid, reqRdata, 2'b01 << expOrder[t], 8'(8'h10 + t));
            end
            reqRequest[expOrder[t]] = 1'b0;
            cacheValid = 1'b0;
            tick();
            checks++;
            if (reqValid !== 2'b00 || cacheRequest !== 1'b0) begin
                errors++; $display("[TB] FAIL b2b_release%0d: got valid=%b req=%b expected 00/0", t, reqValid, cacheRequest);
            end
            reqRequest[expOrder[t]] = 1'b1;
        end
        reqRequest = 2'b00;
    endtask

    task automatic test_evict();
        applyReset();
        reqAddr[1] = 32'h0000_0040;
        reqRequest = 2'b10;
        tick();
        checks++;
        if (grantId !== 1'b1 || cacheAddr !== 32'h40 || cacheOperation !== INST_READ) begin
            errors++; $display("[TB] FAIL evict_grant: got id=%0d addr=%h op=%0d expected 1/40/1", grantId, cacheAddr, cacheOperation);
        end
        cacheValid = 1'b1;
        cacheEvict = 1'b1;
        cacheRdata = 8'h5A;
        tick();
        checks++;
        if (reqValid !== 2'b10 || reqEvict !== 2'b10 || reqRdata !== 8'h5A) begin
            errors++; $display("[TB] FAIL evict_complete: got valid=%b evict=%b rdata=%h expected 10/10/5a", reqValid, reqEvict, reqRdata);
        end
        reqRequest = 2'b00;
        cacheEvict = 1'b0;
        tick();
        checks++;
        if (reqEvict !== 2'b10) begin
            errors++; $display("[TB] FAIL evict_hold: got evict=%b expected 10", reqEvict);
        end
        cacheValid = 1'b0;
        tick();
        checks++;
        if (reqEvict !== 2'b00 || reqValid !== 2'b00) begin
            errors++; $display("[TB] FAIL evict_release: got evict=%b valid=%b expected 00/00", reqEvict, reqValid);
        end
        reqAddr[1] = 32'h0000_0200;
    endtask

    task automatic test_release_order();
        applyReset();
        reqRequest = 2'b01;
        tick();
        cacheValid = 1'b1;
        tick();
        reqRequest = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (reqValid !== 2'b01) begin
                errors++; $display("[TB] FAIL rel_req_first_hold%0d: got valid=%b expected 01", c, reqValid);
            end
        end
        cacheValid = 1'b0;
        tick();
        checks++;
        if (reqValid !== 2'b00) begin
            errors++; $display("[TB] FAIL rel_req_first_clear: got valid=%b expected 00", reqValid);
        end
        reqRequest = 2'b01;
        tick();
        checks++;
        if (cacheRequest !== 1'b1 || grantId !== 1'b0) begin
            errors++; $display("[TB] FAIL rel_regrant: got req=%b id=%0d expected 1/0", cacheRequest, grantId);
        end
        cacheValid = 1'b1;
        tick();
        cacheValid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (reqValid !== 2'b01) begin
                errors++; $display("[TB] FAIL rel_valid_first_hold%0d: got valid=%b expected 01", c, reqValid);
            end
        end
        reqRequest = 2'b00;
        tick();
        checks++;
        if (reqValid !== 2'b00) begin
            errors++; $display("[TB] FAIL rel_valid_first_clear: got valid=%b expected 00", reqValid);
        end
        tick();
        checks++;
        if (cacheRequest !== 1'b0) begin
            errors++; $display("[TB] FAIL rel_idle: got req=%b expected 0", cacheRequest);
        end
    endtask

    task automatic test_reset_mid();
        applyReset();
        reqRequest = 2'b01;
        tick();
        reset      = 1'b1;
        reqRequest = 2'b10;
        tick();
        checks++;
        if (cacheRequest !== 1'b0 || reqValid !== 2'b00 || grantId !== 1'b0 || cacheAddr !== 32'h0 || cacheWdata !== 8'h0) begin
            errors++; $display("[TB] FAIL mid_reset_outputs: got req=%b valid=%b id=%0d addr=%h wdata=%h expected all 0",
                               cacheRequest, reqValid, grantId, cacheAddr, cacheWdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (cacheRequest !== 1'b1 || grantId !== 1'b1 || cacheAddr !== 32'h200 || cacheWdata !== 8'h77) begin
            errors++; $display("[TB] FAIL mid_reset_regrant: got req=%b id=%0d addr=%h wdata=%h expected 1/1/200/77",
                               cacheRequest, grantId, cacheAddr, cacheWdata);
        end
        cacheValid = 1'b1;
        tick();
        checks++;
        if (reqValid !== 2'b10) begin
            errors++; $display("[TB] FAIL mid_reset_complete: got valid=%b expected 10", reqValid);
        end
        reqRequest = 2'b00;
        cacheValid = 1'b0;
        tick();
    endtask

    task automatic test_early_drop();
        bit granted;
        applyReset();
        reqRequest = 2'b01;
        tick();
        reqRequest = 2'b00;
        tick();
        checks++;
        if (cacheRequest !== 1'b1) begin
            errors++; $display("[TB] FAIL drop_still_requesting: got req=%b expected 1", cacheRequest);
        end
        cacheValid = 1'b1;
        cacheRdata = 8'hC3;
        tick();
        checks++;
        if (reqValid !== 2'b01 || cacheRequest !== 1'b0 || reqRdata !== 8'hC3) begin
            errors++; $display("[TB] FAIL drop_complete: got valid=%b req=%b rdata=%h expected 01/0/c3", reqValid, cacheRequest, reqRdata);
        end
        cacheValid = 1'b0;
        tick();
        checks++;
        if (reqValid !== 2'b00) begin
            errors++; $display("[TB] FAIL drop_release: got valid=%b expected 00", reqValid);
        end
        reqRequest = 2'b10;
        granted = 1'b0;
        for (int c = 0; c < 10 && !granted; c++) begin
            tick();
            if (cacheRequest === 1'b1) granted = 1'b1;
        end
        checks++;
        if (!granted || grantId !== 1'b1) begin
            errors++; $display("[TB] FAIL drop_no_hang: got granted=%b id=%0d expected 1/1", granted, grantId);
        end
        reqRequest = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_back_to_back();
        test_evict();
        test_release_order();
        test_reset_mid();
        test_early_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
